mbist_fail_log: RTL and testbench

Fail-address logger and repair-allocation stage sitting directly downstream of the `mbist` controller. It consumes the controller's `start`, `fail`, `fail_addr` and `done` outputs and records each unique failing address into a small spare-row table. After the test completes, it reports whether the memory is repairable with the available spares and offers indexed readout of the logged addresses. Repair logic downstream uses this result to steer accesses to spare rows.

---
 rtl/mbist_pkg.sv | 11 +
 rtl/mbist_fail_cam.sv | 51 +++++
 rtl/mbist_fail_log.sv | 91 +++++++++
 tb/tb_mbist_fail_log.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// mbist_pkg: shared state encoding, default table depth and width helpers for mbist blocks
package mbist_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, COMPLETE} state_t;
  localparam int ENTRIES_DEF = 4;
  function automatic int cnt_w(int n);
    return $clog2(n + 1);
  endfunction
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mbist_fail_cam.sv
// mbist_fail_cam: address storage with valid bits, parallel match and indexed read; lookup port with MBIST_REMAP_EN
module mbist_fail_cam import mbist_pkg::*; #(
  parameter int addr = 3,
  parameter int ENTRIES = ENTRIES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          we,
  input  logic [idx_w(ENTRIES)-1:0]     wr_idx,
  input  logic [addr-1:0]               wr_addr,
  input  logic [addr-1:0]               dd_addr,
  output logic                          dd_hit,
  input  logic [idx_w(ENTRIES)-1:0]     rd_idx,
  output logic [addr-1:0]               rd_data
`ifdef MBIST_REMAP_EN
  ,
  input  logic [addr-1:0]               lk_addr,
  output logic                          lk_hit,
  output logic [idx_w(ENTRIES)-1:0]     lk_idx
`endif
);
  localparam int IW = idx_w(ENTRIES);
  logic [addr-1:0] mem [ENTRIES];
  logic [ENTRIES-1:0] vld, dd_m;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld <= '0;
    end else if (we) begin
      mem[wr_idx] <= wr_addr;
      vld[wr_idx] <= 1'b1;
    end
  end
  always_comb begin
    dd_m = '0;
    for (int i = 0; i < ENTRIES; i++) dd_m[i] = vld[i] && mem[i] == dd_addr;
  end
  assign dd_hit = |dd_m;
  assign rd_data = int'(rd_idx) < ENTRIES ? mem[rd_idx] : '0;
`ifdef MBIST_REMAP_EN
  logic [ENTRIES-1:0] lk_m;
  always_comb begin
    lk_m = '0;
    lk_idx = '0;
    for (int i = 0; i < ENTRIES; i++) lk_m[i] = vld[i] && mem[i] == lk_addr;
    // scan downward so the lowest matching entry wins
    for (int i = ENTRIES - 1; i >= 0; i--) if (lk_m[i]) lk_idx = IW'(i);
  end
  assign lk_hit = |lk_m;
`endif
endmodule

// File: rtl/mbist_fail_log.sv
// mbist_fail_log: logs unique mbist failing addresses into a spare-row table and reports repairability.
// Define MBIST_REMAP_EN to add the registered remap lookup port (lk_*).
module mbist_fail_log import mbist_pkg::*; #(
  parameter int addr = 3,
  parameter int ENTRIES = ENTRIES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          fail,
  input  logic [addr-1:0]               fail_addr,
  input  logic                          done,
  output logic [cnt_w(ENTRIES)-1:0]     log_count,
  output logic                          overflow,
  output logic                          log_ready,
  output logic                          repairable,
  input  logic                          rd_en,
  input  logic [idx_w(ENTRIES)-1:0]     rd_idx,
  output logic                          rd_valid,
  output logic [addr-1:0]               rd_addr
`ifdef MBIST_REMAP_EN
  ,
  input  logic [addr-1:0]               lk_addr,
  output logic                          lk_hit,
  output logic [idx_w(ENTRIES)-1:0]     lk_idx
`endif
);
  localparam int CW = cnt_w(ENTRIES);
  localparam int IW = idx_w(ENTRIES);
  state_t state_q, state_d;
  logic [CW-1:0] count_q;
  logic ovf_q, dd_hit, full, log_fail, we, rd_ok;
  logic [addr-1:0] cam_rd;
`ifdef MBIST_REMAP_EN
  logic cam_lk_hit;
  logic [IW-1:0] cam_lk_idx;
`endif
  mbist_fail_cam #(.addr(addr), .ENTRIES(ENTRIES)) u_cam (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .we      (we),
    .wr_idx  (count_q[IW-1:0]),
    .wr_addr (fail_addr),
    .dd_addr (fail_addr),
    .dd_hit  (dd_hit),
    .rd_idx  (rd_idx),
    .rd_data (cam_rd)
`ifdef MBIST_REMAP_EN
    ,
    .lk_addr (lk_addr),
    .lk_hit  (cam_lk_hit),
    .lk_idx  (cam_lk_idx)
`endif
  );
  assign full = count_q == CW'(ENTRIES);
  assign log_fail = state_q == ARMED && !start && fail && !dd_hit;
  assign we = log_fail && !full;
  assign rd_ok = rd_en && CW'(rd_idx) < count_q;
  always_comb state_d = start ? ARMED : (state_q == ARMED && done) ? COMPLETE : state_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q <= 1'b0;
      rd_valid <= 1'b0;
      rd_addr <= '0;
    end else begin
      state_q <= state_d;
      count_q <= start ? '0 : count_q + CW'(we);
      ovf_q <= start ? 1'b0 : ovf_q | (log_fail & full);
      rd_valid <= rd_ok;
      rd_addr <= rd_ok ? cam_rd : '0;
    end
  end
  assign log_count = count_q;
  assign overflow = ovf_q;
  assign log_ready = state_q == COMPLETE;
  assign repairable = log_ready & ~ovf_q;
`ifdef MBIST_REMAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_hit <= 1'b0;
      lk_idx <= '0;
    end else begin
      lk_hit <= log_ready & cam_lk_hit;
      lk_idx <= (log_ready & cam_lk_hit) ? cam_lk_idx : '0;
    end
  end
`endif
endmodule

// File: tb/tb_mbist_fail_log.sv
// tb_mbist_fail_log: directed scoreboard bench for mbist_fail_log; lookup checks need MBIST_REMAP_EN
module tb_mbist_fail_log;
  localparam int LC = 0, OV = 1, LR = 2, RP = 3, RV = 4, RA = 5, LH = 6, LI = 7;
  typedef struct {int cyc; int fld; int val;} exp_t;
  logic clk = 0, rst = 1, start = 0, fail = 0, done = 0, rd_en = 0;
  logic [2:0] fail_addr = 0, rd_addr, lk_addr = 0;
  logic [2:0] log_count;
  logic [1:0] rd_idx = 0, lk_idx;
  logic overflow, log_ready, repairable, rd_valid, lk_hit;
  int cyc = 0, checks = 0, fails = 0;
  exp_t q[$], keep[$];
  int rdq[$];
  string fname [8] = '{"log_count", "overflow", "log_ready", "repairable", "rd_valid", "rd_addr", "lk_hit", "lk_idx"};
  int ov_a [5] = '{1, 2, 3, 5, 6};

  mbist_fail_log #(.addr(3), .ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .fail(fail), .fail_addr(fail_addr), .done(done),
    .log_count(log_count), .overflow(overflow), .log_ready(log_ready), .repairable(repairable),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_addr(rd_addr)
`ifdef MBIST_REMAP_EN
    , .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_idx(lk_idx)
`endif
  );
`ifndef MBIST_REMAP_EN
  assign lk_hit = 1'b0;
  assign lk_idx = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fv(int f);
    case (f)
      LC: return int'(log_count);
      OV: return int'(overflow);
      LR: return int'(log_ready);
      RP: return int'(repairable);
      RV: return int'(rd_valid);
      RA: return int'(rd_addr);
      LH: return int'(lk_hit);
      default: return int'(lk_idx);
    endcase
  endfunction

  always @(negedge clk) begin
    keep = {};
    foreach (q[i]) begin
      if (q[i].cyc == cyc) begin
        checks++;
        if (fv(q[i].fld) != q[i].val) begin
          fails++;
          $display("FAIL %s: got %0d expected %0d at cycle %0d", fname[q[i].fld], fv(q[i].fld), q[i].val, cyc);
        end
      end else keep.push_back(q[i]);
    end
    q = keep;
    if (rd_valid) begin
      checks++;
      if (rdq.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: got rd_valid=1 rd_addr=%0d expected no readout at cycle %0d", rd_addr, cyc);
      end else begin
        int e;
        e = rdq.pop_front();
        if (int'(rd_addr) != e) begin
          fails++;
          $display("FAIL rd_data: got %0d expected %0d at cycle %0d", rd_addr, e, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_next(int f, int v);
    exp_t e;
    e.cyc = cyc + 1;
    e.fld = f;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic drv(logic s, logic f, logic [2:0] a, logic d);
    start = s;
    fail = f;
    fail_addr = a;
    done = d;
  endtask

  initial begin
    tick();
    for (int f = 0; f < 8; f++) expect_next(f, 0);
    tick();
    rst = 0;
    // single stuck bit, repeated in separate cycles
    drv(1, 0, 0, 0); tick();
    drv(0, 1, 4, 0); expect_next(LC, 1); expect_next(LR, 0); tick();
    drv(0, 0, 0, 0); tick();
    drv(0, 1, 4, 0); tick();
    drv(0, 0, 0, 0); tick();
    drv(0, 1, 4, 0); expect_next(LC, 1); tick();
    drv(0, 0, 0, 1); expect_next(LC, 1); expect_next(OV, 0); expect_next(LR, 1); expect_next(RP, 1); tick();
    drv(0, 0, 0, 0); rd_en = 1; rd_idx = 0; rdq.push_back(4); expect_next(RV, 1); tick();
    rd_en = 0; expect_next(RV, 0); expect_next(RA, 0); tick();
    // overflow on the fifth unique address
    drv(1, 0, 0, 0); expect_next(LC, 0); expect_next(LR, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, 3'(ov_a[i]), 0);
      if (i == 3) begin expect_next(LC, 4); expect_next(OV, 0); end
      if (i == 4) begin expect_next(LC, 4); expect_next(OV, 1); end
      tick();
    end
    drv(0, 0, 0, 1); expect_next(LR, 1); expect_next(RP, 0); expect_next(OV, 1); tick();
    drv(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; rd_idx = 2'(i); rdq.push_back(ov_a[i]); tick();
    end
    rd_en = 0;
    // simultaneous fail+done, fail after completion, start+fail
    drv(1, 0, 0, 0); expect_next(OV, 0); tick();
    drv(0, 1, 7, 1); expect_next(LC, 1); expect_next(LR, 1); tick();
    drv(0, 1, 5, 0); expect_next(LC, 1); tick();
    drv(1, 1, 2, 0); expect_next(LC, 0); expect_next(LR, 0); tick();
    drv(0, 1, 2, 1); expect_next(LC, 1); expect_next(LR, 1); tick();
    // reset in the middle of a test
    drv(1, 0, 0, 0); tick();
    drv(0, 1, 3, 0); expect_next(LC, 1); tick();
    drv(0, 0, 0, 0); rst = 1; rd_en = 1; rd_idx = 0;
    for (int f = 0; f < 8; f++) expect_next(f, 0);
    tick();
    rst = 0; rd_en = 0;
    drv(0, 1, 5, 0); expect_next(LC, 0); tick();
    drv(0, 0, 0, 1); expect_next(LR, 0); tick();
    // readout bounds with two entries while armed
    drv(1, 0, 0, 0); tick();
    drv(0, 1, 1, 0); tick();
    drv(0, 1, 6, 0); expect_next(LC, 2); tick();
    drv(0, 1, 6, 0); expect_next(LC, 2); tick();
    drv(0, 0, 0, 0); rd_en = 1; rd_idx = 3; expect_next(RV, 0); expect_next(RA, 0); tick();
    rd_idx = 2; expect_next(RV, 0); expect_next(RA, 0); tick();
    rd_idx = 1; rdq.push_back(6); expect_next(RV, 1); tick();
    rd_en = 0; tick();
`ifdef MBIST_REMAP_EN
    drv(1, 0, 0, 0); tick();
    drv(0, 1, 6, 0); tick();
    drv(0, 1, 2, 0); tick();
    drv(0, 0, 0, 0); lk_addr = 2; expect_next(LH, 0); tick();
    drv(0, 0, 0, 1); expect_next(LH, 0); tick();
    drv(0, 0, 0, 0); expect_next(LH, 1); expect_next(LI, 1); tick();
    lk_addr = 6; expect_next(LH, 1); expect_next(LI, 0); tick();
    lk_addr = 0; expect_next(LH, 0); expect_next(LI, 0); tick();
`endif
    tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expect: got %0d unchecked expected 0", q.size());
    end
    checks++;
    if (rdq.size() != 0) begin
      fails++;
      $display("FAIL pending_readout: got %0d missing readouts expected 0", rdq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
